// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
//   Shared types and helpers for the parallel-in/serial-out serializer.
//   - state_t     : FSM state encoding (IDLE, SHIFT)
//   - flen_f()    : frame length in bits for a given data width
//   - even_parity : XOR reduction of a data word (zero-extended to PAR_MAX_W)
//
//   Optional feature macro: PISO_PARITY_EN
//     defined   -> frame carries one trailing even-parity bit (FLEN = WIDTH+1)
//     undefined -> frame is data bits only (FLEN = WIDTH)
// -----------------------------------------------------------------------------
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Widest word the parity helper accepts; zero-extension does not change
   // the XOR of the word, so narrower words are passed in widened.
   localparam int PAR_MAX_W = 64;

   function automatic int flen_f(input int width);
`ifdef PISO_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// -----------------------------------------------------------------------------
// piso_bit_counter
//   Frame bit counter. Clears to 0 on clr, otherwise increments on inc.
//   tc flags the final bit of the frame (cnt == FLEN-1).
//
//   Ports
//     clk   in   system clock
//     rst_n in   synchronous active-low reset
//     clr   in   reload counter to 0 (new frame or end of frame)
//     inc   in   advance to the next frame bit
//     cnt   out  current bit index, $clog2(FLEN+1) bits
//     tc    out  terminal count, current bit is the last of the frame
// -----------------------------------------------------------------------------
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int FLEN = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       inc,
   output logic [$clog2(FLEN+1)-1:0]  cnt,
   output logic                       tc
);

   localparam int CW = $clog2(FLEN+1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tc = (cnt == CW'(FLEN-1));

endmodule

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//   Accepts a WIDTH-bit word over valid/ready and shifts it out one bit per
//   clock on registered sout/sout_valid/sout_last. A new word can be accepted
//   on the cycle the last bit of the current frame is presented, giving
//   gapless back-to-back frames.
//
//   Parameters
//     WIDTH     data word width (2..PAR_MAX_W)
//     MSB_FIRST 1: bit WIDTH-1 goes first, 0: bit 0 goes first
//
//   Ports
//     clk        in   system clock
//     rst_n      in   synchronous active-low reset
//     din        in   parallel word, sampled only at the accept edge
//     din_valid  in   producer has a word on din
//     din_ready  out  combinational; depends on state/count only
//     sout       out  serial data bit (registered)
//     sout_valid out  sout carries a frame bit (registered)
//     sout_last  out  sout is the final frame bit (registered)
//     busy       out  frame in flight, same as sout_valid
//
//   Optional feature macro: PISO_PARITY_EN appends an even-parity bit
//   (XOR of the accepted word) after the data bits.
// -----------------------------------------------------------------------------
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_last,
   output logic             busy
);

   localparam int FLEN = flen_f(WIDTH);
   localparam int CW   = $clog2(FLEN+1);

   state_t           state;
   // sreg holds the data bits not yet presented on sout, aligned so the
   // next one to go out always sits at the output end.
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             tc;
   logic             accept;
   logic             cnt_clr;
   logic             cnt_inc;

   logic             load_bit;
   logic [WIDTH-1:0] load_rest;
   logic             data_bit;
   logic [WIDTH-1:0] shift_rest;
   logic             next_bit;

   // ready never looks at din_valid, so there is no valid->ready loop
   assign din_ready = rst_n && ((state == IDLE) || tc);
   assign accept    = din_valid && din_ready;
   assign busy      = sout_valid;

   // Counter reloads on every accept and when a frame ends without a
   // follow-on word, so it never wraps and sits at 0 while idle.
   assign cnt_clr = accept || ((state == SHIFT) && tc);
   assign cnt_inc = (state == SHIFT) && !tc;

   piso_bit_counter #(
      .FLEN (FLEN)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .cnt   (cnt),
      .tc    (tc)
   );

   // Bit ordering: first bit comes straight from din at accept, the rest
   // of the word is parked in sreg already shifted by one position.
   always_comb begin
      load_bit   = 1'b0;
      load_rest  = '0;
      data_bit   = 1'b0;
      shift_rest = '0;
      if (MSB_FIRST) begin
         load_bit   = din[WIDTH-1];
         load_rest  = {din[WIDTH-2:0], 1'b0};
         data_bit   = sreg[WIDTH-1];
         shift_rest = {sreg[WIDTH-2:0], 1'b0};
      end else begin
         load_bit   = din[0];
         load_rest  = {1'b0, din[WIDTH-1:1]};
         data_bit   = sreg[0];
         shift_rest = {1'b0, sreg[WIDTH-1:1]};
      end
   end

`ifdef PISO_PARITY_EN
   logic par_q;

   // Parity is captured with the word, so later din changes cannot leak in
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else if (accept) begin
         par_q <= even_parity(PAR_MAX_W'(din));
      end
   end

   // Once the final data bit (index WIDTH-1) is on the line, parity is next
   assign next_bit = (cnt == CW'(WIDTH-1)) ? par_q : data_bit;
`else
   assign next_bit = data_bit;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         sreg       <= '0;
         sout       <= 1'b0;
         sout_valid <= 1'b0;
         sout_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= SHIFT;
                  sreg       <= load_rest;
                  sout       <= load_bit;
                  sout_valid <= 1'b1;
                  sout_last  <= 1'b0;
               end
            end
            SHIFT: begin
               if (!tc) begin
                  sreg      <= shift_rest;
                  sout      <= next_bit;
                  // registered copy of the counter's terminal flag for
                  // the bit about to be presented
                  sout_last <= (cnt == CW'(FLEN-2));
               end else if (accept) begin
                  // gapless follow-on frame
                  sreg       <= load_rest;
                  sout       <= load_bit;
                  sout_valid <= 1'b1;
                  sout_last  <= 1'b0;
               end else begin
                  state      <= IDLE;
                  sreg       <= '0;
                  sout       <= 1'b0;
                  sout_valid <= 1'b0;
                  sout_last  <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               sout       <= 1'b0;
               sout_valid <= 1'b0;
               sout_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer
//   Directed bench for piso_serializer. Two instances share all inputs: one
//   MSB-first, one LSB-first. Each cycle a 9-bit status word is sampled on
//   the falling edge:
//     {sout_m, sout_l, valid_m, valid_l, last_m, last_l, ready_m, ready_l, busy_m}
//   Frame length follows PISO_PARITY_EN (parity values are hand-computed).
// -----------------------------------------------------------------------------
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
   localparam int FLEN = 9;
`else
   localparam int FLEN = 8;
`endif

   localparam logic [8:0] ST_RESET = 9'b000000000;
   localparam logic [8:0] ST_IDLE  = 9'b000000110;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] din;
   logic       din_valid;

   logic rdy_m, so_m, sv_m, sl_m, bz_m;
   logic rdy_l, so_l, sv_l, sl_l, bz_l;

   int vectors    = 0;
   int miscompares = 0;

   logic [8:0] st [0:63];

   always #5 clk = ~clk;

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .din_ready(rdy_m), .sout(so_m), .sout_valid(sv_m),
      .sout_last(sl_m), .busy(bz_m)
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .din_ready(rdy_l), .sout(so_l), .sout_valid(sv_l),
      .sout_last(sl_l), .busy(bz_l)
   );

   function automatic logic [8:0] snap();
      return {so_m, so_l, sv_m, sv_l, sl_m, sl_l, rdy_m, rdy_l, bz_m};
   endfunction

   // expected serial bit i of word w (p = hand-computed even parity)
   function automatic logic exp_bit(input logic [7:0] w, input logic p,
                                    input int i, input bit msb);
      if (i >= 8) return p;
      return msb ? w[7-i] : w[i];
   endfunction

   // expected status on frame cycle i (0-based)
   function automatic logic [8:0] fexp(input logic [7:0] w, input logic p,
                                       input int i);
      logic l;
      l = (i == FLEN-1);
      return {exp_bit(w, p, i, 1'b1), exp_bit(w, p, i, 1'b0), 2'b11,
              l, l, l, l, 1'b1};
   endfunction

   // Offer w starting at a falling edge; returns on the falling edge of
   // frame cycle 1 with din_valid dropped and din scrambled.
   task automatic send(input logic [7:0] w);
      int n = 0;
      din       = w;
      din_valid = 1'b1;
      while (!rdy_m && n < 20) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (rdy_m !== 1'b1) begin
         $display("FAIL send_ready_timeout: ready=%b want 1", rdy_m);
         miscompares++;
      end
      @(negedge clk);
      din_valid = 1'b0;
      din       = ~w;
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         st[i] = snap();
         if (i < n-1) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      din       = 8'hFF;
      din_valid = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (snap() !== ST_RESET) begin
         $display("FAIL reset_state: got %b want %b", snap(), ST_RESET);
         miscompares++;
      end
      din_valid = 1'b0;
      rst_n     = 1'b1;
      #1;
      vectors++;
      if (snap() !== ST_IDLE) begin
         $display("FAIL reset_release: got %b want %b", snap(), ST_IDLE);
         miscompares++;
      end
      @(negedge clk);
      vectors++;
      if (snap() !== ST_IDLE) begin
         $display("FAIL reset_idle: got %b want %b", snap(), ST_IDLE);
         miscompares++;
      end
   endtask

   task automatic test_basic();
      logic [8:0] e;
      send(8'hA5);
      capture(FLEN);
      for (int i = 0; i < FLEN; i++) begin
         e = fexp(8'hA5, 1'b0, i);
         vectors++;
         if (st[i] !== e) begin
            $display("FAIL basic_A5 cyc%0d: got %b want %b", i+1, st[i], e);
            miscompares++;
         end
      end
      @(negedge clk);
      vectors++;
      if (snap() !== ST_IDLE) begin
         $display("FAIL basic_idle: got %b want %b", snap(), ST_IDLE);
         miscompares++;
      end
   endtask

   task automatic test_bit_order();
      logic [8:0] e;
      send(8'h01);
      capture(FLEN);
      for (int i = 0; i < FLEN; i++) begin
         e = fexp(8'h01, 1'b1, i);
         vectors++;
         if (st[i] !== e) begin
            $display("FAIL order_01 cyc%0d: got %b want %b", i+1, st[i], e);
            miscompares++;
         end
      end
      @(negedge clk);
      vectors++;
      if (snap() !== ST_IDLE) begin
         $display("FAIL order_idle: got %b want %b", snap(), ST_IDLE);
         miscompares++;
      end
   endtask

   task automatic test_back_to_back();
      logic [8:0] e;
      din       = 8'hFF;
      din_valid = 1'b1;
      @(negedge clk);
      din = 8'h00;
      for (int i = 0; i < 2*FLEN; i++) begin
         st[i] = snap();
         if (i == FLEN) din_valid = 1'b0;  // second word taken on last bit
         if (i < 2*FLEN-1) @(negedge clk);
      end
      for (int i = 0; i < 2*FLEN; i++) begin
         e = (i < FLEN) ? fexp(8'hFF, 1'b0, i) : fexp(8'h00, 1'b0, i-FLEN);
         vectors++;
         if (st[i] !== e) begin
            $display("FAIL b2b cyc%0d: got %b want %b", i+1, st[i], e);
            miscompares++;
         end
      end
      @(negedge clk);
      vectors++;
      if (snap() !== ST_IDLE) begin
         $display("FAIL b2b_idle: got %b want %b", snap(), ST_IDLE);
         miscompares++;
      end
   endtask

   task automatic test_mid_reset();
      logic [8:0] e;
      send(8'hF0);
      capture(3);
      for (int i = 0; i < 3; i++) begin
         e = fexp(8'hF0, 1'b0, i);
         vectors++;
         if (st[i] !== e) begin
            $display("FAIL midrst_pre cyc%0d: got %b want %b", i+1, st[i], e);
            miscompares++;
         end
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({rdy_m, rdy_l} !== 2'b00) begin
         $display("FAIL midrst_ready_low: got %b want 00", {rdy_m, rdy_l});
         miscompares++;
      end
      @(negedge clk);
      vectors++;
      if (snap() !== ST_RESET) begin
         $display("FAIL midrst_clear: got %b want %b", snap(), ST_RESET);
         miscompares++;
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (snap() !== ST_IDLE) begin
         $display("FAIL midrst_release: got %b want %b", snap(), ST_IDLE);
         miscompares++;
      end
      send(8'h3C);
      capture(FLEN);
      for (int i = 0; i < FLEN; i++) begin
         e = fexp(8'h3C, 1'b0, i);
         vectors++;
         if (st[i] !== e) begin
            $display("FAIL midrst_3C cyc%0d: got %b want %b", i+1, st[i], e);
            miscompares++;
         end
      end
      @(negedge clk);
      vectors++;
      if (snap() !== ST_IDLE) begin
         $display("FAIL midrst_idle: got %b want %b", snap(), ST_IDLE);
         miscompares++;
      end
   endtask

   // Valid pulses on frame cycle 4 (ready low: 8'hAA must be ignored) and on
   // the last-bit cycle (8'h96 taken); din churns every other cycle.
   task automatic test_stall();
      logic [8:0] e;
      int cyc;
      din       = 8'hC3;
      din_valid = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2*FLEN; i++) begin
         st[i] = snap();
         cyc   = i + 1;
         if (cyc == 4) begin
            din = 8'hAA;  din_valid = 1'b1;
         end else if (cyc == FLEN) begin
            din = 8'h96;  din_valid = 1'b1;
         end else begin
            din = 8'(cyc * 37);  din_valid = 1'b0;
         end
         if (i < 2*FLEN-1) @(negedge clk);
      end
      din_valid = 1'b0;
      for (int i = 0; i < 2*FLEN; i++) begin
         e = (i < FLEN) ? fexp(8'hC3, 1'b0, i) : fexp(8'h96, 1'b0, i-FLEN);
         vectors++;
         if (st[i] !== e) begin
            $display("FAIL stall cyc%0d: got %b want %b", i+1, st[i], e);
            miscompares++;
         end
      end
      @(negedge clk);
      vectors++;
      if (snap() !== ST_IDLE) begin
         $display("FAIL stall_idle: got %b want %b", snap(), ST_IDLE);
         miscompares++;
      end
   endtask

   // With the parity build the ninth bit is the parity bit; otherwise these
   // frames close on data bit 8.
   task automatic test_parity();
      logic [8:0] e;
      send(8'h07);
      capture(FLEN);
      for (int i = 0; i < FLEN; i++) begin
         e = fexp(8'h07, 1'b1, i);
         vectors++;
         if (st[i] !== e) begin
            $display("FAIL parity_07 cyc%0d: got %b want %b", i+1, st[i], e);
            miscompares++;
         end
      end
      @(negedge clk);
      send(8'h03);
      capture(FLEN);
      for (int i = 0; i < FLEN; i++) begin
         e = fexp(8'h03, 1'b0, i);
         vectors++;
         if (st[i] !== e) begin
            $display("FAIL parity_03 cyc%0d: got %b want %b", i+1, st[i], e);
            miscompares++;
         end
      end
      @(negedge clk);
      vectors++;
      if (snap() !== ST_IDLE) begin
         $display("FAIL parity_idle: got %b want %b", snap(), ST_IDLE);
         miscompares++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_bit_order();
      test_back_to_back();
      test_mid_reset();
      test_stall();
      test_parity();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter that accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on a posedge-registered serial line. It drives single-bit capture chains built from posedge D flip-flops and shift-in receivers. It sits between a word-oriented producer and a 1-bit link, and it supports gapless back-to-back words.

## Interface
- WIDTH, 8: data word width; must be ≥2.
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.

- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit, registered.
- sout_valid  output  1  sout carries a frame bit this cycle, registered.
- sout_last  output  1  current sout bit is the final bit of the frame, registered.
- busy  output  1  a frame is in flight; equals sout_valid.

## Operation
- Frame length: FLEN = WIDTH, or WIDTH+1 with parity enabled (see Configuration).
- States:
  - IDLE: no frame in flight.
  - SHIFT: transmitting a frame; holds shift register sreg[WIDTH-1:0] and bit counter cnt.
- Accept occurs when din_valid && din_ready at a posedge.
- din_ready rules:
  - Combinational: 1 in IDLE.
  - 1 in SHIFT while the last frame bit is being presented (sout_last=1).
  - 0 otherwise.
  - Forced 0 while rst_n=0.
- On accept:
  - sreg ← din, cnt ← 0, state → SHIFT.
  - The first frame bit is presented on sout in the same edge.
- Each SHIFT cycle:
  - sout presents one bit, then sreg shifts toward the output end and cnt increments.
  - On the cycle cnt = FLEN-1, sout_last=1.
- After the last bit:
  - If an accept occurs at that same edge, the next frame's first bit follows with no idle cycle.
  - Otherwise state → IDLE, sout_valid ← 0, sout_last ← 0, sout ← 0.
- Producer rules:
  - din is sampled only at the accept edge; later changes on din are ignored.
  - din_valid may drop without a transfer; there is no penalty.
- Counter width is $clog2(FLEN+1). The counter never wraps: it is reloaded to 0 on every accept.
- Reset (rst_n=0 at a posedge), including mid-frame:
  - state → IDLE, and sreg, cnt, sout, sout_valid, sout_last all → 0.
  - A partial frame is discarded and never resumed.
- Reset values: sout=0, sout_valid=0, sout_last=0, busy=0, din_ready=0 during reset and 1 on the first cycle after release.

## Timing
- Latency: first bit appears on sout 1 cycle after the accept edge. The last bit appears FLEN cycles after it.
- Throughput: one word per FLEN cycles with continuous din_valid.
- Outputs sout, sout_valid and sout_last are flop outputs. din_ready is the only combinational output and depends on state/cnt only, never on din_valid. There is no combinational valid→ready path.
- Receivers sample sout on posedge when sout_valid=1 and use sout_last to frame words.

## Configuration
- PISO_PARITY_EN:
  - Defined: FLEN = WIDTH+1. After the WIDTH data bits, one even-parity bit (XOR of the accepted din) is sent, and sout_last marks the parity bit. Parity is computed at accept and held in a register.
  - Undefined: FLEN = WIDTH, with no parity logic or register; sout_last marks the final data bit.

## Structure
- Package piso_pkg holds:
  - the state enum (IDLE, SHIFT);
  - a function computing FLEN from WIDTH and the macro;
  - the even-parity function.
- Sub-module piso_bit_counter is a loadable up-counter with a terminal-count flag (cnt == FLEN-1) that drives sout_last/din_ready.
- The top level holds the FSM, sreg and output flops.

## Test plan
- Basic frame: WIDTH=8, MSB_FIRST=1, accept 8'hA5.
  - sout reads 1,0,1,0,0,1,0,1 on cycles 1–8 after accept.
  - sout_last=1 only on cycle 8; then IDLE with sout_valid=0.
- Bit order: MSB_FIRST=0, accept 8'hA5.
  - sout reads 1,0,1,0,0,1,0,1 (bit0 first); accept 8'h01 → a 1 on cycle 1 only.
- Back-to-back: din_valid held high with 8'hFF then 8'h00.
  - Second accept occurs on the sout_last cycle.
  - 16 consecutive valid bits (eight 1s, then eight 0s) with no gap; din_ready is low on cycles 1–7 of each frame.
- Mid-frame reset: accept 8'hF0, assert rst_n=0 on cycle 3 for 1 cycle.
  - All outputs are 0 the next cycle and din_ready=1 after release.
  - A new word 8'h3C then transmits cleanly.
- Handshake stall and din change: din_valid pulses with 3-cycle gaps, and din is toggled while busy.
  - Only accepted words are transmitted, unaltered.
  - No accept occurs while din_ready=0.
- PISO_PARITY_EN defined: accept 8'h07.
  - 9 bits are sent, and the ninth bit is 1 with sout_last=1.
  - Accept 8'h03 → ninth bit is 0.
